cell_alu_stream: RTL and testbench
==================================

CELL_ALU_STREAM -- requirements
Module: cell_alu_stream

Interface
REQ-001 Parameter CH_WIDTH, default 8, bits per colour channel.
REQ-002 Parameter CH_NUM, default 3, channels per pixel (channel CH_NUM-1 in MSBs: red, green, blue order at default).
REQ-003 Parameter CELL_N, default 3, cell edge in pixels; odd, >= 3.
REQ-004 Parameter SAT_MODE, default 1; 1 = clamp results to [0, 2^CH_WIDTH-1], 0 = wrap modulo 2^CH_WIDTH.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 opcode  input  4  operation, encoding of shared opcode enum.
REQ-010 cell_a  input  CELL_N*CELL_N*CH_NUM*CH_WIDTH  operand cell A, row-major, pixel [0][0] in MSBs.
REQ-011 cell_b  input  same  operand cell B.
REQ-012 user_in  input  CH_WIDTH  immediate operand.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_pixel  output  CH_NUM*CH_WIDTH  result pixel.
REQ-016 out_err  output  1  opcode was illegal (12..15); qualified by out_valid.

Function
REQ-017 FSM states IDLE, EXEC, ACC, DIVD, HOLD; in_ready = 1 only in IDLE.
REQ-018 Accept when in_valid & in_ready at an edge; opcode, cell_a centre pixel, cell_b centre pixel, user_in and full cell_a captured into registers; later input changes ignored.
REQ-019 After accept: opcode AVG -> ACC, any other -> EXEC.
REQ-020 EXEC lasts 1 cycle, registers result, -> HOLD; out_valid rises 2 edges after accept edge.
REQ-021 ACC lasts CELL_N cycles, adding one captured row (CELL_N pixels) per cycle into per-channel accumulators of width CH_WIDTH+clog2(CELL_N*CELL_N); accumulators cleared on accept.
REQ-022 DIVD lasts 1 cycle: per channel, result = accumulator / (CELL_N*CELL_N), truncating, exact integer division (not shift); -> HOLD; AVG out_valid rises CELL_N+2 edges after accept.
REQ-023 HOLD: out_valid = 1, out_pixel/out_err stable; on out_ready -> IDLE at that edge; otherwise stays indefinitely.
REQ-024 Per-channel ops on centre pixels (index (CELL_N-1)/2), unsigned: ADD a+b, ADDI a+u, SUB a-b, SUBI a-u, MULT a*b, MULTI a*u, DIV2 a>>1, INV ~a, AND a&b, OR a|b, NOR ~(a|b).
REQ-025 ADD/ADDI/MULT/MULTI overflow: SAT_MODE=1 -> all-ones; SAT_MODE=0 -> low CH_WIDTH bits.
REQ-026 SUB/SUBI underflow: SAT_MODE=1 -> 0; SAT_MODE=0 -> two's-complement wrap.
REQ-027 Illegal opcode: out_pixel = centre pixel of cell_a, out_err = 1, EXEC path latency; all legal opcodes give out_err = 0.
REQ-028 Channels are independent; saturation of one never affects another.
REQ-029 in_valid asserted while not IDLE has no effect; no request is queued.
REQ-030 out_ready while out_valid = 0 has no effect.

Reset
REQ-031 rst_n low: FSM -> IDLE, out_valid = 0, out_pixel = 0, out_err = 0, accumulators and operand registers = 0, immediately and without clk.
REQ-032 in_ready = 1 during and after reset (IDLE); reset mid-ACC or mid-HOLD discards the operation with no output.
REQ-033 Release of rst_n does not itself produce out_valid.

Structure
REQ-034 Shared package holds opcode enum (ADD=0 .. AVG=11), parameterised pixel/cell typedefs, and centre-index and accumulator-width constants.
REQ-035 One sub-module cell_chan_alu: combinational single-channel op with SAT_MODE, instantiated CH_NUM times.
REQ-036 No division operator outside DIVD datapath; no latches.

Verification
REQ-037 ADD, centres a=(200,10,255) b=(100,20,1), SAT_MODE=1 -> out_pixel=(255,30,255), out_valid 2 edges after accept.
REQ-038 SUBI user_in=50 on a=(40,50,60): SAT_MODE=1 -> (0,0,10); SAT_MODE=0 -> (246,0,10).
REQ-039 AVG, CELL_N=3, all nine pixels (9,18,255) except one (0,0,0) -> (8,16,226), out_valid 5 edges after accept.
REQ-040 MULTI user_in=2 on a=(100,128,3) with out_ready held low 10 cycles -> (200,255,6) held stable, in_ready=0 throughout, then one transfer.
REQ-041 opcode=13 -> out_pixel = cell_a centre, out_err=1; next ADD request -> out_err=0.
REQ-042 rst_n pulsed low during ACC cycle 2 -> out_valid stays 0, in_ready=1 next cycle, subsequent AVG correct.

Source files
------------

// File: rtl/cell_alu_stream_pkg.sv
// Shared types and geometry helpers for the cell ALU stream block.
package cell_alu_stream_pkg;

    // Operation encoding; values 12..15 are illegal and reported through out_err.
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDI  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBI  = 4'd3,
        OP_MULT  = 4'd4,
        OP_MULTI = 4'd5,
        OP_DIV2  = 4'd6,
        OP_INV   = 4'd7,
        OP_AND   = 4'd8,
        OP_OR    = 4'd9,
        OP_NOR   = 4'd10,
        OP_AVG   = 4'd11
    } opcode_e;

    localparam logic [3:0] FIRST_ILLEGAL_OP = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_ACC,
        ST_DIVD,
        ST_HOLD
    } state_e;

    // Default geometry and the pixel/cell types it implies.
    localparam int DEF_CH_WIDTH = 8;
    localparam int DEF_CH_NUM   = 3;
    localparam int DEF_CELL_N   = 3;

    typedef logic [DEF_CH_NUM-1:0][DEF_CH_WIDTH-1:0] pixel_t;
    typedef pixel_t [DEF_CELL_N*DEF_CELL_N-1:0]      cell_t;

    // Row/column index of the centre pixel of an odd-edged cell.
    function automatic int centre_idx(input int cell_n);
        return (cell_n - 1) / 2;
    endfunction

    // Accumulator width that holds the sum of every pixel of one channel.
    function automatic int acc_width(input int ch_width, input int cell_n);
        return ch_width + $clog2(cell_n * cell_n);
    endfunction

    localparam int DEF_CENTRE_IDX = centre_idx(DEF_CELL_N);
    localparam int DEF_ACC_W      = acc_width(DEF_CH_WIDTH, DEF_CELL_N);

endpackage

// File: rtl/cell_chan_alu.sv
// Combinational single-channel operator with optional saturation.
module cell_chan_alu
    import cell_alu_stream_pkg::*;
#(
    parameter int CH_WIDTH = 8,
    parameter int SAT_MODE = 1
) (
    input  opcode_e             op_i,
    input  logic [CH_WIDTH-1:0] a_i,
    input  logic [CH_WIDTH-1:0] b_i,
    input  logic [CH_WIDTH-1:0] u_i,
    output logic [CH_WIDTH-1:0] y_o
);

    localparam logic [CH_WIDTH-1:0] ONES = '1;

    logic [CH_WIDTH-1:0]   opnd;
    logic [CH_WIDTH:0]     sum;
    logic [CH_WIDTH:0]     diff;
    logic [2*CH_WIDTH-1:0] prod;

    // Evaluate every arithmetic form at full width, then pick and clamp per opcode.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        y_o  = a_i;
        opnd = (op_i inside {OP_ADDI, OP_SUBI, OP_MULTI}) ? u_i : b_i;
        sum  = {1'b0, a_i} + {1'b0, opnd};
        diff = {1'b0, a_i} - {1'b0, opnd};
        prod = {{CH_WIDTH{1'b0}}, a_i} * {{CH_WIDTH{1'b0}}, opnd};
        case (op_i)
            OP_ADD, OP_ADDI:
                y_o = (SAT_MODE != 0 && sum[CH_WIDTH]) ? ONES : sum[CH_WIDTH-1:0];
            OP_SUB, OP_SUBI:
                y_o = (SAT_MODE != 0 && diff[CH_WIDTH]) ? '0 : diff[CH_WIDTH-1:0];
            OP_MULT, OP_MULTI:
                y_o = (SAT_MODE != 0 && |prod[2*CH_WIDTH-1:CH_WIDTH]) ? ONES
                                                                      : prod[CH_WIDTH-1:0];
            OP_DIV2: y_o = a_i >> 1;
            OP_INV:  y_o = ~a_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_NOR:  y_o = ~(a_i | b_i);
            // AVG is handled by the accumulator path; illegal opcodes pass a through.
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/cell_alu_stream.sv
// Single-request pixel-cell ALU: per-channel centre-pixel ops or a whole-cell average.
module cell_alu_stream
    import cell_alu_stream_pkg::*;
#(
    parameter int CH_WIDTH = 8,
    parameter int CH_NUM   = 3,
    parameter int CELL_N   = 3,
    parameter int SAT_MODE = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [3:0]                              opcode,
    input  logic [CELL_N*CELL_N*CH_NUM*CH_WIDTH-1:0] cell_a,
    input  logic [CELL_N*CELL_N*CH_NUM*CH_WIDTH-1:0] cell_b,
    input  logic [CH_WIDTH-1:0]                     user_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [CH_NUM*CH_WIDTH-1:0]              out_pixel,
    output logic                                    out_err
);

    localparam int PIX_W   = CH_NUM * CH_WIDTH;
    localparam int NPIX    = CELL_N * CELL_N;
    localparam int CELL_W  = NPIX * PIX_W;
    localparam int CTR     = centre_idx(CELL_N);
    localparam int CTR_OFF = (NPIX - 1 - (CTR * CELL_N + CTR)) * PIX_W;
    localparam int ACC_W   = acc_width(CH_WIDTH, CELL_N);
    localparam int ROW_W   = $clog2(CELL_N);

    localparam logic [ACC_W-1:0] DIVISOR  = ACC_W'(NPIX);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELL_N - 1);

    state_e              state_q, state_d;
    logic [3:0]          op_q;
    logic [PIX_W-1:0]    ca_q;
    logic [PIX_W-1:0]    cb_q;
    logic [CH_WIDTH-1:0] u_q;
    logic [CELL_W-1:0]   cell_q;
    logic [ROW_W-1:0]    row_q;
    logic [ACC_W-1:0]    acc_q   [CH_NUM];
    logic [ACC_W-1:0]    row_sum [CH_NUM];
    logic [PIX_W-1:0]    res_q;
    logic                err_q;
    logic [PIX_W-1:0]    alu_y;
    logic                accept;
    logic                unused_cell_b;

    // Only the centre pixel of cell_b takes part in any operation.
    assign unused_cell_b = ^cell_b;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign out_pixel = res_q;
    assign out_err   = err_q;
    assign accept    = in_ready && in_valid;

    // One channel operator per colour channel, fed from the captured centre pixels.
    for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
        cell_chan_alu #(
            .CH_WIDTH (CH_WIDTH),
            .SAT_MODE (SAT_MODE)
        ) u_chan_alu (
            .op_i (opcode_e'(op_q)),
            .a_i  (ca_q[k*CH_WIDTH +: CH_WIDTH]),
            .b_i  (cb_q[k*CH_WIDTH +: CH_WIDTH]),
            .u_i  (u_q),
            .y_o  (alu_y[k*CH_WIDTH +: CH_WIDTH])
        );
    end

    // Sum of the captured cell_a row selected by row_q, per channel.
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            row_sum[k] = '0;
            for (int c = 0; c < CELL_N; c++) begin
                row_sum[k] = row_sum[k] + ACC_W'(cell_q[(NPIX - 1 - (int'(row_q) * CELL_N + c)) * PIX_W
                                                       + k * CH_WIDTH +: CH_WIDTH]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic: AVG walks the accumulator path, everything else takes one EXEC cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = (opcode == OP_AVG) ? ST_ACC : ST_EXEC;
            ST_EXEC: state_d = ST_HOLD;
            ST_ACC:  if (row_q == LAST_ROW) state_d = ST_DIVD;
            ST_DIVD: state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, row accumulation and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all operand and accumulator registers are reset so an aborted request leaves no residue.
            op_q   <= '0;
            ca_q   <= '0;
            cb_q   <= '0;
            u_q    <= '0;
            cell_q <= '0;
            row_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) acc_q[k] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= opcode;
                        ca_q   <= cell_a[CTR_OFF +: PIX_W];
                        cb_q   <= cell_b[CTR_OFF +: PIX_W];
                        u_q    <= user_in;
                        cell_q <= cell_a;
                        row_q  <= '0;
                        for (int k = 0; k < CH_NUM; k++) acc_q[k] <= '0;
                    end
                end
                ST_EXEC: begin
                    res_q <= alu_y;
                    err_q <= (op_q >= FIRST_ILLEGAL_OP);
                end
                ST_ACC: begin
                    row_q <= row_q + 1'b1;
                    for (int k = 0; k < CH_NUM; k++) acc_q[k] <= acc_q[k] + row_sum[k];
                end
                ST_DIVD: begin
                    err_q <= 1'b0;
                    for (int k = 0; k < CH_NUM; k++) begin
                        res_q[k*CH_WIDTH +: CH_WIDTH] <= CH_WIDTH'(acc_q[k] / DIVISOR);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_alu_stream.sv
// Directed self-checking bench: a saturating and a wrapping instance run in lockstep.
module tb_cell_alu_stream;

    localparam int W  = 8;
    localparam int PW = 3 * W;
    localparam int CW = 9 * PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [3:0]    opcode = '0;
    logic [CW-1:0] cell_a = '0;
    logic [CW-1:0] cell_b = '0;
    logic [W-1:0]  user_in = '0;

    logic          in_ready1, out_valid1, out_err1;
    logic [PW-1:0] out_pixel1;
    logic          in_ready0, out_valid0, out_err0;
    logic [PW-1:0] out_pixel0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cell_alu_stream #(.CH_WIDTH(8), .CH_NUM(3), .CELL_N(3), .SAT_MODE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .opcode(opcode), .cell_a(cell_a), .cell_b(cell_b), .user_in(user_in),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pixel(out_pixel1), .out_err(out_err1)
    );

    cell_alu_stream #(.CH_WIDTH(8), .CH_NUM(3), .CELL_N(3), .SAT_MODE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .opcode(opcode), .cell_a(cell_a), .cell_b(cell_b), .user_in(user_in),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pixel(out_pixel0), .out_err(out_err0)
    );

    // Builds a 3x3 cell: given centre, one optional odd pixel, filler elsewhere.
    function automatic logic [CW-1:0] make_cell(input logic [PW-1:0] centre, input logic [PW-1:0] other,
                                                input int odd_idx, input logic [PW-1:0] odd_pix);
        logic [CW-1:0] c;
        c = '0;
        for (int p = 0; p < 9; p++) begin
            c[(8 - p) * PW +: PW] = (p == 4) ? centre : ((p == odd_idx) ? odd_pix : other);
        end
        return c;
    endfunction

    // Presents one request, then counts edges (accept edge = 1) until out_valid; -1 on timeout.
    task automatic issue(input logic [3:0] op, input logic [CW-1:0] a_cell, input logic [CW-1:0] b_cell,
                         input logic [W-1:0] u, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = op;
        cell_a   = a_cell;
        cell_b   = b_cell;
        user_in  = u;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        opcode   = 4'hC;
        cell_a   = ~cell_a;
        cell_b   = ~cell_b;
        user_in  = ~user_in;
        while (out_valid1 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (out_valid1 !== 1'b1) lat = -1;
    endtask

    // Accepts the held result with a single out_ready pulse.
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready1); end
        checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", out_valid1, out_valid0); end
        checks++; if (out_pixel1 !== '0) begin failures++; $display("FAIL reset_out_pixel: got %h expected 000000", out_pixel1); end
        checks++; if (out_err1 !== 1'b0) begin failures++; $display("FAIL reset_out_err: got %b expected 0", out_err1); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL post_reset_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid1, in_ready1); end
    endtask

    task automatic test_add();
        int lat;
        issue(4'd0, make_cell(24'hC80AFF, 24'h123456, -1, '0), make_cell(24'h641401, 24'h5A5A5A, -1, '0), 8'd0, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency: got %0d expected 2", lat); end
        checks++; if (out_pixel1 !== 24'hFF1EFF) begin failures++; $display("FAIL add_sat: got %h expected ff1eff", out_pixel1); end
        checks++; if (out_pixel0 !== 24'h2C1E00) begin failures++; $display("FAIL add_wrap: got %h expected 2c1e00", out_pixel0); end
        checks++; if (out_err1 !== 1'b0) begin failures++; $display("FAIL add_err: got %b expected 0", out_err1); end
        consume();
    endtask

    task automatic test_subi();
        int lat;
        issue(4'd3, make_cell(24'h28323C, 24'h123456, -1, '0), make_cell(24'h777777, 24'h5A5A5A, -1, '0), 8'd50, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL subi_latency: got %0d expected 2", lat); end
        checks++; if (out_pixel1 !== 24'h00000A) begin failures++; $display("FAIL subi_sat: got %h expected 00000a", out_pixel1); end
        checks++; if (out_pixel0 !== 24'hF6000A) begin failures++; $display("FAIL subi_wrap: got %h expected f6000a", out_pixel0); end
        consume();
    endtask

    task automatic test_avg();
        int lat;
        issue(4'd11, make_cell(24'h0912FF, 24'h0912FF, 0, 24'h000000), make_cell('0, 24'h5A5A5A, -1, '0), 8'd0, lat);
        checks++; if (lat !== 5) begin failures++; $display("FAIL avg_latency: got %0d expected 5", lat); end
        checks++; if (out_pixel1 !== 24'h0810E2) begin failures++; $display("FAIL avg_sat: got %h expected 0810e2", out_pixel1); end
        checks++; if (out_pixel0 !== 24'h0810E2) begin failures++; $display("FAIL avg_wrap: got %h expected 0810e2", out_pixel0); end
        checks++; if (out_err1 !== 1'b0) begin failures++; $display("FAIL avg_err: got %b expected 0", out_err1); end
        consume();
    endtask

    task automatic test_multi_hold();
        int lat;
        int seen;
        issue(4'd5, make_cell(24'h648003, 24'h123456, -1, '0), make_cell(24'h010101, 24'h5A5A5A, -1, '0), 8'd2, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL multi_latency: got %0d expected 2", lat); end
        // A competing request stays asserted while the result is held.
        in_valid = 1'b1;
        opcode   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || out_pixel1 !== 24'hC8FF06 || out_pixel0 !== 24'hC80006) begin
                failures++;
                $display("FAIL multi_hold[%0d]: got valid=%b ready=%b pix=%h/%h expected valid=1 ready=0 pix=c8ff06/c80006",
                         i, out_valid1, in_ready1, out_pixel1, out_pixel0);
            end
            @(negedge clk);
        end
        consume();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid1 === 1'b1 || in_ready1 !== 1'b1) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL multi_single_transfer: got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_illegal();
        int lat;
        issue(4'd13, make_cell(24'h010203, 24'h123456, -1, '0), make_cell(24'h040506, 24'h5A5A5A, -1, '0), 8'd9, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
        checks++; if (out_pixel1 !== 24'h010203) begin failures++; $display("FAIL illegal_pixel: got %h expected 010203", out_pixel1); end
        checks++; if (out_err1 !== 1'b1 || out_err0 !== 1'b1) begin failures++; $display("FAIL illegal_err: got %b/%b expected 1/1", out_err1, out_err0); end
        consume();
        issue(4'd0, make_cell(24'h010203, 24'h123456, -1, '0), make_cell(24'h040506, 24'h5A5A5A, -1, '0), 8'd0, lat);
        checks++; if (out_err1 !== 1'b0) begin failures++; $display("FAIL legal_after_illegal_err: got %b expected 0", out_err1); end
        checks++; if (out_pixel1 !== 24'h050709) begin failures++; $display("FAIL legal_after_illegal_pixel: got %h expected 050709", out_pixel1); end
        consume();
    endtask

    task automatic test_op_table();
        logic [3:0]    op [8];
        logic [PW-1:0] a  [8];
        logic [PW-1:0] b  [8];
        logic [W-1:0]  u  [8];
        logic [PW-1:0] e1 [8];
        logic [PW-1:0] e0 [8];
        int lat;
        op[0] = 4'd2;  a[0] = 24'h0AC805; b[0] = 24'h146405; u[0] = 8'd0; e1[0] = 24'h006400; e0[0] = 24'hF66400;
        op[1] = 4'd4;  a[1] = 24'h100F00; b[1] = 24'h101109; u[1] = 8'd0; e1[1] = 24'hFFFF00; e0[1] = 24'h00FF00;
        op[2] = 4'd6;  a[2] = 24'hFF0180; b[2] = 24'h0; u[2] = 8'd0; e1[2] = 24'h7F0040; e0[2] = 24'h7F0040;
        op[3] = 4'd7;  a[3] = 24'h00FF0F; b[3] = 24'h0; u[3] = 8'd0; e1[3] = 24'hFF00F0; e0[3] = 24'hFF00F0;
        op[4] = 4'd8;  a[4] = 24'hF0AAFF; b[4] = 24'h3C550F; u[4] = 8'd0; e1[4] = 24'h30000F; e0[4] = 24'h30000F;
        op[5] = 4'd9;  a[5] = 24'hF0AAFF; b[5] = 24'h3C550F; u[5] = 8'd0; e1[5] = 24'hFCFFFF; e0[5] = 24'hFCFFFF;
        op[6] = 4'd10; a[6] = 24'hF0AAFF; b[6] = 24'h3C550F; u[6] = 8'd0; e1[6] = 24'h030000; e0[6] = 24'h030000;
        op[7] = 4'd1;  a[7] = 24'hFAFB01; b[7] = 24'h0; u[7] = 8'd5; e1[7] = 24'hFFFF06; e0[7] = 24'hFF0006;
        for (int i = 0; i < 8; i++) begin
            issue(op[i], make_cell(a[i], 24'h123456, -1, '0), make_cell(b[i], 24'h5A5A5A, -1, '0), u[i], lat);
            checks++;
            if (lat !== 2 || out_pixel1 !== e1[i] || out_pixel0 !== e0[i] || out_err1 !== 1'b0) begin
                failures++;
                $display("FAIL op_table[%0d] op=%0d: got lat=%0d pix=%h/%h err=%b expected lat=2 pix=%h/%h err=0",
                         i, op[i], lat, out_pixel1, out_pixel0, out_err1, e1[i], e0[i]);
            end
            consume();
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        // Abort during the second ACC cycle.
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = 4'd11;
        cell_a   = make_cell(24'h0912FF, 24'h0912FF, -1, '0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL abort_acc_async: got valid=%b ready=%b expected valid=0 ready=1", out_valid1, in_ready1); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL abort_acc_ready: got %b expected 1", in_ready1); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid1 !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_acc_no_output: got %0d valid cycles expected 0", seen); end
        issue(4'd11, make_cell(24'h0C005A, 24'h030609, -1, '0), make_cell('0, 24'h5A5A5A, -1, '0), 8'd0, lat);
        checks++; if (lat !== 5 || out_pixel1 !== 24'h040512) begin failures++; $display("FAIL avg_after_abort: got lat=%0d pix=%h expected lat=5 pix=040512", lat, out_pixel1); end
        consume();
        // Abort while a result is held.
        issue(4'd0, make_cell(24'h010101, 24'h123456, -1, '0), make_cell(24'h010101, 24'h5A5A5A, -1, '0), 8'd0, lat);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid1 !== 1'b0 || out_pixel1 !== '0 || out_err1 !== 1'b0) begin failures++; $display("FAIL abort_hold: got valid=%b pix=%h err=%b expected 0/000000/0", out_valid1, out_pixel1, out_err1); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL abort_hold_idle: got valid=%b ready=%b expected 0/1", out_valid1, in_ready1); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_subi();
        test_avg();
        test_multi_hold();
        test_illegal();
        test_op_table();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
